// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the two-requester I2C arbiter.
//   state_e          FSM state encoding (IDLE/GRANT/START/WAIT/COMPLETE)
//   REQ_0, REQ_1     requester index constants
//   TIMEOUT_DEFAULT  default WAIT-cycle budget before a transaction is aborted
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GRANT    = 3'd1,
    ST_START    = 3'd2,
    ST_WAIT     = 3'd3,
    ST_COMPLETE = 3'd4
  } state_e;

  localparam logic REQ_0 = 1'b0;
  localparam logic REQ_1 = 1'b1;

  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd1000;

endpackage

// File: rtl/i2c_timer.sv
// i2c_timer: 16-bit saturating cycle counter for the WAIT timeout.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-low reset (count -> 0)
//   clr      in   clear count to 0 (wins over en)
//   en       in   count one cycle, saturating at TIMEOUT-1
//   expired  out  high while the count equals TIMEOUT-1
module i2c_timer
  import i2c_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LIMIT = TIMEOUT - 16'd1;

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 16'd0;
    end else if (en && (count_q != LIMIT)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin arbiter sharing one I2C master between two
// requesters. A winning request is captured in IDLE, granted for one cycle,
// started on the master, then waited on until m_done or timeout.
// Ports:
//   clk, rst               clock / synchronous active-low reset
//   req0/1, addr0/1, data0/1  requester request, 7-bit address, write byte
//   gnt0/1                 one-cycle grant pulse (addr/data captured)
//   done0/1, err0/1        one-cycle completion pulse and its error flag
//   m_start, m_addr, m_data  start pulse and held address/byte to master
//   m_done, m_nack         master completion pulse and NACK flag
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       err0,
  output logic       err1,
  output logic       m_start,
  output logic [6:0] m_addr,
  output logic [7:0] m_data,
  input  logic       m_done,
  input  logic       m_nack
);

  state_e     state_q, state_d;
  logic       winner_q, winner_d;
  logic       last_grant_q, last_grant_d;
  logic       err_q, err_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;

  logic       expired;
  logic       in_grant;
  logic       in_complete;
  logic [1:0] gnt_vec;
  logic [1:0] done_vec;
  logic [1:0] err_vec;

  // Counter is cleared in START so the first WAIT cycle sees count 0.
  i2c_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == ST_START),
    .en      (state_q == ST_WAIT),
    .expired (expired)
  );

  // State register, plus the datapath registers that travel with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      winner_q     <= REQ_0;
      last_grant_q <= REQ_1;
      err_q        <= 1'b0;
      addr_q       <= 7'd0;
      data_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  // Next-state logic. m_done/m_nack are only looked at in WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (req0 || req1) state_d = ST_GRANT;
      ST_GRANT:    state_d = ST_START;
      ST_START:    state_d = ST_WAIT;
      ST_WAIT:     if (m_done || expired) state_d = ST_COMPLETE;
      ST_COMPLETE: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Arbitration, capture and error latch.
  always_comb begin
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    addr_d       = addr_q;
    data_d       = data_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          // Contention goes to whoever was not served last; a lone
          // request wins outright.
          if (req0 && req1) winner_d = ~last_grant_q;
          else              winner_d = req1 ? REQ_1 : REQ_0;
          addr_d = (winner_d == REQ_1) ? addr1 : addr0;
          data_d = (winner_d == REQ_1) ? data1 : data0;
          err_d  = 1'b0;
        end
      end
      ST_GRANT: last_grant_d = winner_q;
      ST_WAIT: begin
        // A completion in the expiry cycle reports the slave's answer.
        if (m_done)       err_d = m_nack;
        else if (expired) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Output decode: pulses come straight from the state, so at most one
  // gnt/done/m_start can be high at a time.
  always_comb begin
    in_grant    = (state_q == ST_GRANT);
    in_complete = (state_q == ST_COMPLETE);
    m_start     = (state_q == ST_START);
    m_addr      = addr_q;
    m_data      = data_q;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign gnt_vec[gi]  = in_grant && (winner_q == 1'(gi));
      assign done_vec[gi] = in_complete && (winner_q == 1'(gi));
      assign err_vec[gi]  = done_vec[gi] && err_q;
    end
  endgenerate

  assign gnt0  = gnt_vec[0];
  assign gnt1  = gnt_vec[1];
  assign done0 = done_vec[0];
  assign done1 = done_vec[1];
  assign err0  = err_vec[0];
  assign err1  = err_vec[1];

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: directed bench for i2c_arbiter with TIMEOUT=8.
module tb_i2c_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [6:0] addr0 = 7'd0, addr1 = 7'd0;
  logic [7:0] data0 = 8'd0, data1 = 8'd0;
  logic       gnt0, gnt1, done0, done1, err0, err1, m_start;
  logic [6:0] m_addr;
  logic [7:0] m_data;
  logic       m_done = 1'b0, m_nack = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  i2c_arbiter #(.TIMEOUT(16'd8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .err0(err0), .err1(err1),
    .m_start(m_start), .m_addr(m_addr), .m_data(m_data),
    .m_done(m_done), .m_nack(m_nack)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"},  {30'd0, gnt1, gnt0}, 0);
    check({tag, "_done"}, {30'd0, done1, done0}, 0);
    check({tag, "_err"},  {30'd0, err1, err0}, 0);
    check({tag, "_mst"},  {31'd0, m_start}, 0);
  endtask

  // Requests must already be driven; the served requester drops its req
  // after seeing its grant.
  task automatic run_txn(input int who, input logic nack,
                         input logic [6:0] ea, input logic [7:0] ed);
    logic [1:0] oh;
    oh = (who == 0) ? 2'b01 : 2'b10;
    step();
    check("gnt", {30'd0, gnt1, gnt0}, {30'd0, oh});
    check("mst_in_grant", {31'd0, m_start}, 0);
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    step();
    check("m_start", {31'd0, m_start}, 1);
    check("gnt_clr", {30'd0, gnt1, gnt0}, 0);
    check("m_addr", {25'd0, m_addr}, {25'd0, ea});
    check("m_data", {24'd0, m_data}, {24'd0, ed});
    step();
    check("wait_mst", {31'd0, m_start}, 0);
    check("wait_done", {30'd0, done1, done0}, 0);
    m_done = 1'b1;
    m_nack = nack;
    step();
    m_done = 1'b0;
    m_nack = 1'b0;
    check("done", {30'd0, done1, done0}, {30'd0, oh});
    check("err", {30'd0, err1, err0}, nack ? {30'd0, oh} : 32'd0);
    check("hold_addr", {25'd0, m_addr}, {25'd0, ea});
    step();
    check("done_clr", {30'd0, done1, done0}, 0);
    $display("[TB] txn req%0d addr=%02h data=%02h nack=%0d", who, ea, ed, nack);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check_quiet("rst");
    check("rst_addr", {25'd0, m_addr}, 0);
    check("rst_data", {24'd0, m_data}, 0);
    rst = 1'b1;
    step();

    // Contention from reset: 0 then 1, twice
    addr0 = 7'h11; data0 = 8'h01; addr1 = 7'h22; data1 = 8'h02;
    for (int r = 0; r < 2; r++) begin
      req0 = 1'b1; req1 = 1'b1;
      run_txn(0, 1'b0, 7'h11, 8'h01);
      run_txn(1, 1'b0, 7'h22, 8'h02);
    end

    // Single requester 0 with ACK
    addr0 = 7'h50; data0 = 8'haa; req0 = 1'b1;
    run_txn(0, 1'b0, 7'h50, 8'haa);

    // Requester 1 NACKed
    addr1 = 7'h3c; data1 = 8'h5a; req1 = 1'b1;
    run_txn(1, 1'b1, 7'h3c, 8'h5a);

    // Timeout: WAIT entered, done/err exactly 8 cycles later
    addr0 = 7'h0f; data0 = 8'hf0; req0 = 1'b1;
    step();
    check("to_gnt", {30'd0, gnt1, gnt0}, 1);
    req0 = 1'b0;
    step();
    step();
    for (int i = 1; i < 8; i++) begin
      step();
      check("to_early_done", {30'd0, done1, done0}, 0);
    end
    step();
    check("to_done", {30'd0, done1, done0}, 1);
    check("to_err", {30'd0, err1, err0}, 1);
    step();
    check("to_done_clr", {30'd0, done1, done0}, 0);
    $display("[TB] txn req0 addr=0f data=f0 timeout");

    // Reset while in WAIT
    addr1 = 7'h44; data1 = 8'h99; req1 = 1'b1;
    step();
    check("rw_gnt", {30'd0, gnt1, gnt0}, 2);
    req1 = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_quiet("rw");
    check("rw_addr", {25'd0, m_addr}, 0);
    check("rw_data", {24'd0, m_data}, 0);
    m_done = 1'b1;
    m_nack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      m_done = 1'b0;
      m_nack = 1'b0;
      check_quiet("rw_after");
    end
    $display("[TB] txn req1 addr=44 data=99 aborted by reset");

    // req1 pulsed during a requester-0 transaction is dropped
    addr0 = 7'h61; data0 = 8'h17; req0 = 1'b1;
    step();
    check("pl_gnt", {30'd0, gnt1, gnt0}, 1);
    req0 = 1'b0;
    step();
    step();
    req1 = 1'b1;
    step();
    req1 = 1'b0;
    m_done = 1'b1;
    step();
    m_done = 1'b0;
    check("pl_done", {30'd0, done1, done0}, 1);
    check("pl_err", {30'd0, err1, err0}, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_quiet("pl_after");
    end
    $display("[TB] txn req0 addr=61 data=17 with req1 pulse dropped");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
